// File: rtl/transport_sched_pkg.sv
// Shared types and constants for the transport scheduler: FSM states,
// legal requester code range, requester count and transport-word layout.
package transport_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int NREQ   = 4;
    localparam int IDX_W  = 2;
    localparam int CODE_W = 4;
    localparam int DATA_W = 8;

    localparam logic [CODE_W-1:0] CODE_MIN = 4'd1;
    localparam logic [CODE_W-1:0] CODE_MAX = 4'd8;

    // Transport word layout: {pad[1:0], src[1:0], code[3:0]}
    localparam int DATA_CODE_LSB = 0;
    localparam int DATA_SRC_LSB  = 4;
    localparam int DATA_PAD_LSB  = 6;

    function automatic logic code_legal(input logic [CODE_W-1:0] c);
        return (c >= CODE_MIN) && (c <= CODE_MAX);
    endfunction

    function automatic logic [DATA_W-1:0] pack_word(input logic [IDX_W-1:0] src,
                                                    input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] w;
        w = 8'h00;
        w[DATA_PAD_LSB +: 2]       = 2'b00;
        w[DATA_SRC_LSB +: IDX_W]   = src;
        w[DATA_CODE_LSB +: CODE_W] = c;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requesting index at or above ptr,
// wrapping modulo 4.
module rr_pick
    import transport_sched_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] win
);

    logic [NREQ-1:0]  rot_s;
    logic [IDX_W-1:0] off_s;
    logic             valid_s;

    // Rotate so that bit k of rot_s is requester (ptr + k) mod 4.
    always_comb begin
        rot_s = req;
        case (ptr)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0],   req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
    end

    // Lowest set bit of the rotated vector is the winner's offset from ptr.
    always_comb begin
        off_s   = 2'd0;
        valid_s = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s   = 2'd0;
                valid_s = 1'b0;
            end
        endcase
    end

    assign valid = valid_s;
    assign win   = ptr + off_s;

endmodule

// File: rtl/transport_sched.sv
// Round-robin scheduler: picks one of four requesters, validates its code and
// presents a single transport word per grant with ready/timeout handling.
module transport_sched
    import transport_sched_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CODE_W-1:0]   code,
    output logic [NREQ-1:0]          gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        data,
    output logic                     err,
    output logic                     tout,
    output logic [7:0]               sent_cnt
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    ptr_r,   ptr_nxt_s;
    logic [IDX_W-1:0]    src_r,   src_nxt_s;
    logic [7:0]          timer_r, timer_nxt_s;
    logic [NREQ-1:0]     gnt_r,   gnt_nxt_s;
    logic                err_r,   err_nxt_s;
    logic                tout_r,  tout_nxt_s;
    logic                valid_r, valid_nxt_s;
    logic [DATA_W-1:0]   data_r,  data_nxt_s;
    logic [7:0]          cnt_r,   cnt_nxt_s;

    logic                pick_valid_s;
    logic [IDX_W-1:0]    pick_win_s;
    logic [CODE_W-1:0]   win_code_s;
    logic                win_legal_s;
    logic                arb_s;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .win   (pick_win_s)
    );

    // Select the winning requester's code nibble.
    always_comb begin
        win_code_s = code[3:0];
        case (pick_win_s)
            2'd0:    win_code_s = code[3:0];
            2'd1:    win_code_s = code[7:4];
            2'd2:    win_code_s = code[11:8];
            2'd3:    win_code_s = code[15:12];
            default: win_code_s = code[3:0];
        endcase
    end

    assign win_legal_s = code_legal(win_code_s);
    // No arbitration while a grant pulse is out, so gnt/err never stretch.
    assign arb_s = (state_r == ST_IDLE) && (gnt_r == 4'b0000) && pick_valid_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_s && win_legal_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready || (timer_r == TIMER_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: next values for every registered output and counter.
    always_comb begin
        gnt_nxt_s   = 4'b0000;
        err_nxt_s   = 1'b0;
        tout_nxt_s  = 1'b0;
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        ptr_nxt_s   = ptr_r;
        src_nxt_s   = src_r;
        timer_nxt_s = timer_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                valid_nxt_s = 1'b0;
                if (arb_s) begin
                    gnt_nxt_s = 4'b0001 << pick_win_s;
                    if (win_legal_s) begin
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = pack_word(pick_win_s, win_code_s);
                        src_nxt_s   = pick_win_s;
                        timer_nxt_s = 8'd0;
                    end else begin
                        err_nxt_s = 1'b1;
                        ptr_nxt_s = pick_win_s + 2'd1;
                    end
                end else begin
                    gnt_nxt_s = 4'b0000;
                end
            end
            ST_SEND: begin
                // Acceptance wins over an expiring timer on the same cycle.
                if (out_ready) begin
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = src_r + 2'd1;
                    if (cnt_r != 8'hFF) begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    valid_nxt_s = 1'b0;
                    tout_nxt_s  = 1'b1;
                    ptr_nxt_s   = src_r + 2'd1;
                end else begin
                    timer_nxt_s = timer_r + 8'd1;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath, counters and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r   <= 2'd0;
            src_r   <= 2'd0;
            timer_r <= 8'd0;
            gnt_r   <= 4'b0000;
            err_r   <= 1'b0;
            tout_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= 8'h00;
            cnt_r   <= 8'd0;
        end else begin
            ptr_r   <= ptr_nxt_s;
            src_r   <= src_nxt_s;
            timer_r <= timer_nxt_s;
            gnt_r   <= gnt_nxt_s;
            err_r   <= err_nxt_s;
            tout_r  <= tout_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign err       = err_r;
    assign tout      = tout_r;
    assign out_valid = valid_r;
    assign data      = data_r;
    assign sent_cnt  = cnt_r;

endmodule

// File: tb/tb_transport_sched.sv
// Bench for transport_sched: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the scheduler rules.
module tb_transport_sched;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data;
    logic        err;
    logic        tout;
    logic [7:0]  sent_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // behavioural model state
    bit m_busy, m_valid, m_err, m_tout;
    int m_ptr, m_src, m_wait, m_cnt, m_gnt, m_data;

    // observation logs
    int glog[$];
    int dlog[$];
    int vcnt, tcnt, ecnt;

    transport_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .code      (code),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .err       (err),
        .tout      (tout),
        .sent_cnt  (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_tout = 1'b0;
        m_ptr = 0; m_src = 0; m_wait = 0; m_cnt = 0; m_gnt = 0; m_data = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int prev, w, c;
        if (!rst) begin
            model_reset();
        end else begin
            prev = m_gnt;
            m_gnt = 0; m_err = 1'b0; m_tout = 1'b0;
            if (m_busy) begin
                if (out_ready) begin
                    m_busy = 1'b0; m_valid = 1'b0;
                    m_ptr = (m_src + 1) % 4;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_busy = 1'b0; m_valid = 1'b0; m_tout = 1'b1;
                        m_ptr = (m_src + 1) % 4;
                    end
                end
            end else if (prev == 0 && req != 4'b0000) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                c = int'((code >> (4 * w)) & 16'h000F);
                m_gnt = 1 << w;
                if (c >= 1 && c <= 8) begin
                    m_busy = 1'b1; m_valid = 1'b1; m_src = w; m_wait = 0;
                    m_data = w * 16 + c;
                end else begin
                    m_err = 1'b1;
                    m_ptr = (w + 1) % 4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("gnt",      32'(gnt),       32'(m_gnt));
        chk("err",      32'(err),       32'(m_err));
        chk("tout",     32'(tout),      32'(m_tout));
        chk("valid",    32'(out_valid), 32'(m_valid));
        chk("data",     32'(data),      32'(m_data));
        chk("sent_cnt", 32'(sent_cnt),  32'(m_cnt));
        for (int i = 0; i < 4; i++)
            if (gnt[i]) begin
                glog.push_back(i);
                dlog.push_back(int'(data));
            end
        if (out_valid) vcnt++;
        if (tout) tcnt++;
        if (err) ecnt++;
    endtask

    // One clock cycle: check what the last edge produced, then drive inputs.
    task automatic cyc(input logic rn, input logic [3:0] r, input logic [15:0] c,
                       input logic rd);
        @(negedge clk);
        check_outputs();
        rst = rn; req = r; code = c; out_ready = rd;
        model_step();
    endtask

    task automatic clear_logs();
        glog.delete(); dlog.delete();
        vcnt = 0; tcnt = 0; ecnt = 0;
    endtask

    task automatic do_reset();
        cyc(1'b0, 4'b0000, 16'h0000, 1'b0);
        cyc(1'b0, 4'b0000, 16'h0000, 1'b0);
        clear_logs();
    endtask

    initial begin
        int exp_g[5];
        int exp_d[5];
        logic [15:0] rc;
        logic        slow;
        rst = 1'b1; req = 4'b0000; code = 16'h0000; out_ready = 1'b0;
        model_reset();
        #1 rst = 1'b0;

        // reset state
        do_reset();

        // single legal request, immediately accepted
        cyc(1'b1, 4'b0001, 16'h0005, 1'b1);
        repeat (4) cyc(1'b1, 4'b0000, 16'h0000, 1'b1);
        chk("r029_ngnt", 32'(glog.size()), 32'd1);
        chk("r029_gidx", 32'(glog[0]), 32'd0);
        chk("r029_data", 32'(dlog[0]), 32'h05);
        chk("r029_vcyc", 32'(vcnt), 32'd1);
        chk("r029_cnt",  32'(sent_cnt), 32'd1);

        // all requesting with code 3: strict rotation
        do_reset();
        repeat (12) cyc(1'b1, 4'b1111, 16'h3333, 1'b1);
        cyc(1'b1, 4'b0000, 16'h0000, 1'b1);
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{8'h03, 8'h13, 8'h23, 8'h33, 8'h03};
        chk("r030_n", 32'(glog.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("r030_g", 32'(glog[i]), 32'(exp_g[i]));
            chk("r030_d", 32'(dlog[i]), 32'(exp_d[i]));
        end

        // illegal code from requester 2, then everyone requests
        do_reset();
        cyc(1'b1, 4'b0100, 16'h5055, 1'b1);
        repeat (6) cyc(1'b1, 4'b1111, 16'h5555, 1'b1);
        chk("r031_g0",  32'(glog[0]), 32'd2);
        chk("r031_g1",  32'(glog[1]), 32'd3);
        chk("r031_err", 32'(ecnt), 32'd1);

        // timeout, then acceptance on the last allowed cycle
        do_reset();
        cyc(1'b1, 4'b0001, 16'h0002, 1'b0);
        repeat (TIMEOUT - 1) cyc(1'b1, 4'b0000, 16'h0000, 1'b0);
        repeat (5) cyc(1'b1, 4'b0000, 16'h0000, 1'b0);
        chk("r032_vcyc", 32'(vcnt), 32'(TIMEOUT));
        chk("r032_tout", 32'(tcnt), 32'd1);
        chk("r032_cnt",  32'(sent_cnt), 32'd0);
        clear_logs();
        cyc(1'b1, 4'b0001, 16'h0002, 1'b0);
        repeat (TIMEOUT - 1) cyc(1'b1, 4'b0000, 16'h0000, 1'b0);
        cyc(1'b1, 4'b0000, 16'h0000, 1'b1);
        repeat (4) cyc(1'b1, 4'b0000, 16'h0000, 1'b0);
        chk("r032b_vcyc", 32'(vcnt), 32'(TIMEOUT));
        chk("r032b_tout", 32'(tcnt), 32'd0);
        chk("r032b_cnt",  32'(sent_cnt), 32'd1);

        // asynchronous reset in the middle of a SEND
        do_reset();
        cyc(1'b1, 4'b0001, 16'h0004, 1'b1);
        cyc(1'b1, 4'b0000, 16'h0000, 1'b1);
        cyc(1'b1, 4'b0001, 16'h0006, 1'b0);
        repeat (3) cyc(1'b1, 4'b0000, 16'h0000, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("r033_valid", 32'(out_valid), 32'd0);
        chk("r033_data",  32'(data), 32'h00);
        chk("r033_cnt",   32'(sent_cnt), 32'd0);
        model_reset();
        cyc(1'b0, 4'b0000, 16'h0000, 1'b0);
        clear_logs();
        cyc(1'b1, 4'b0010, 16'h0070, 1'b1);
        cyc(1'b1, 4'b0000, 16'h0000, 1'b1);
        chk("r033_g", 32'(glog.size() == 1 ? glog[0] : -1), 32'd1);
        chk("r033_d", 32'(dlog[0]), 32'h17);

        // sent counter saturation
        do_reset();
        repeat (620) cyc(1'b1, 4'b0001, 16'h0001, 1'b1);
        cyc(1'b1, 4'b0000, 16'h0000, 1'b1);
        chk("r034_sat", 32'(sent_cnt), 32'd255);

        // randomized traffic against the model
        do_reset();
        slow = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) slow = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < 4; j++) rc[4*j +: 4] = 4'($urandom_range(0, 10));
            cyc(($urandom_range(0, 399) != 0),
                ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                rc,
                slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0));
        end
        cyc(1'b1, 4'b0000, 16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
